result_display: RTL and testbench

Downstream consumer of the GCD processor. On each rising edge of the processor's `Halt`, it captures the processor's 8-bit `Output` and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, 3-digit, active-low 7-segment display with leading-zero blanking. The block sits between the `Processor` and the board-level display pins.

---
 rtl/result_display_if.sv | 25 ++
 rtl/result_display.sv | 165 ++++++++++++++++
 tb/tb_result_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/result_display_if.sv
// Signal bundle between the GCD processor side (master) and result_display (slave).
// Halt/Data come from the processor. Everything else is produced by the display block.
interface result_display_if;
  // Capture protocol: a capture happens at a clock edge where Halt is 1 and
  // was 0 at the previous edge; Data is sampled at that same edge.
  // While Busy is 1, further Halt rises are ignored. Valid qualifies Bcd.
  logic        Halt;
  logic [7:0]  Data;
  logic        Busy;
  logic        Valid;
  logic [11:0] Bcd;
  logic [2:0]  Anode;
  logic [6:0]  Segments;
  logic        dbg_state;  // 1 while the converter FSM is in CONVERT

  modport master (
    output Halt, Data,
    input  Busy, Valid, Bcd, Anode, Segments, dbg_state
  );

  modport slave (
    input  Halt, Data,
    output Busy, Valid, Bcd, Anode, Segments, dbg_state
  );
endinterface

// File: rtl/result_display.sv
// Captures the processor result on a Halt rise, converts it to BCD with a
// sequential double-dabble engine and scans it onto a 3-digit 7-segment display.
module result_display #(
  parameter int REFRESH_DIV = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  result_display_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t      state, state_next;
  logic        halt_d;
  logic [7:0]  shift_q;
  logic [11:0] scratch_q;
  logic [2:0]  iter_q;
  logic        busy_q, valid_q;
  logic [11:0] bcd_q;
  logic        capture;
  logic        last_iter;

  logic [11:0] adj;
  logic [11:0] scratch_next;
  logic [7:0]  shift_next;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]  digit_idx;
  logic [2:0]  anode_q, anode_next;
  logic [6:0]  seg_q, seg_next;
  logic [3:0]  digit;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign capture   = bus.Halt & ~halt_d;
  assign last_iter = (iter_q == 3'd7);

  // One double-dabble step: adjust every nibble, then shift data MSB into ones LSB.
  assign adj          = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  assign scratch_next = {adj[10:0], shift_q[7]};
  assign shift_next   = {shift_q[6:0], 1'b0};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture)   state_next = CONVERT;
      CONVERT: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      halt_d    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      halt_d <= bus.Halt;
      if (state == IDLE) begin
        if (capture) begin
          shift_q   <= bus.Data;
          scratch_q <= '0;
          iter_q    <= '0;
          valid_q   <= 1'b0;
          busy_q    <= 1'b1;
        end
      end else begin
        shift_q   <= shift_next;
        scratch_q <= scratch_next;
        iter_q    <= iter_q + 3'd1;
        if (last_iter) begin
          bcd_q   <= scratch_next;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  // Scan runs freely; anode and segments are registered together from digit_idx.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      anode_q     <= 3'b110;
      seg_q       <= 7'h7F;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      anode_q <= anode_next;
      seg_q   <= seg_next;
    end
  end

  always_comb begin
    anode_next = 3'b110;
    digit      = bcd_q[3:0];
    blank      = 1'b1;
    case (digit_idx)
      2'd0: begin
        anode_next = 3'b110;
        digit      = bcd_q[3:0];
        blank      = ~valid_q;
      end
      2'd1: begin
        anode_next = 3'b101;
        digit      = bcd_q[7:4];
        blank      = ~valid_q | ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0));
      end
      2'd2: begin
        anode_next = 3'b011;
        digit      = bcd_q[11:8];
        blank      = ~valid_q | (bcd_q[11:8] == 4'd0);
      end
      default: begin
        anode_next = 3'b110;
        blank      = 1'b1;
      end
    endcase
    seg_next = blank ? 7'h7F : seg7(digit);
  end

  assign bus.Busy      = busy_q;
  assign bus.Valid     = valid_q;
  assign bus.Bcd       = bcd_q;
  assign bus.Anode     = anode_q;
  assign bus.Segments  = seg_q;
  assign bus.dbg_state = (state == CONVERT);

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: capture latency, BCD results, blanking,
// retrigger rejection, reset abort and display scan dwell.
module tb_result_display;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  result_display_if bus ();

  result_display #(.REFRESH_DIV(DIV)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_anode(input logic [2:0] target, input string tag);
    int k;
    k = 0;
    while (bus.Anode !== target && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.Anode), 32'(target));
  endtask

  task automatic dwell(input logic [2:0] target, output int n);
    n = 0;
    while (bus.Anode === target && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Halt low for two edges, then rise with d; returns sampled right after edge N.
  task automatic start_capture(input logic [7:0] d);
    bus.Halt = 1'b0;
    tick();
    tick();
    bus.Halt = 1'b1;
    bus.Data = d;
    tick();
  endtask

  task automatic finish_capture(input logic [11:0] exp_bcd, input string tag);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    end
    check({tag, "_valid_n7"}, 32'(bus.Valid), 32'd0);
    tick();
    check({tag, "_busy_done"}, 32'(bus.Busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.Valid), 32'd1);
    check({tag, "_bcd"}, 32'(bus.Bcd), 32'(exp_bcd));
    bus.Halt = 1'b0;
  endtask

  task automatic check_digits(input logic [6:0] hun, input logic [6:0] ten,
                              input logic [6:0] one, input string tag);
    for (int i = 0; i < 3 * DIV + 2; i++) tick();
    wait_anode(3'b110, {tag, "_anode_ones"});
    check({tag, "_seg_ones"}, 32'(bus.Segments), 32'(one));
    wait_anode(3'b101, {tag, "_anode_tens"});
    check({tag, "_seg_tens"}, 32'(bus.Segments), 32'(ten));
    wait_anode(3'b011, {tag, "_anode_hun"});
    check({tag, "_seg_hun"}, 32'(bus.Segments), 32'(hun));
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.Halt = 1'b0;
    bus.Data = 8'd0;

    // Reset asserted mid-cycle takes effect immediately.
    #3 rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_valid", 32'(bus.Valid), 32'd0);
    check("rst_bcd", 32'(bus.Bcd), 32'h000);
    check("rst_anode", 32'(bus.Anode), 32'b110);
    check("rst_seg", 32'(bus.Segments), 32'h7F);
    tick();
    tick();
    rst = 1'b0;

    // Free-running scan with blank segments.
    wait_anode(3'b101, "scan_reach_101");
    check("scan_seg_blank_tens", 32'(bus.Segments), 32'h7F);
    dwell(3'b101, n);
    check("scan_dwell_101", 32'(n), 32'(DIV));
    check("scan_next_011", 32'(bus.Anode), 32'b011);
    check("scan_seg_blank_hun", 32'(bus.Segments), 32'h7F);
    dwell(3'b011, n);
    check("scan_dwell_011", 32'(n), 32'(DIV));
    check("scan_next_110", 32'(bus.Anode), 32'b110);
    dwell(3'b110, n);
    check("scan_dwell_110", 32'(n), 32'(DIV));

    // Full scale.
    start_capture(8'd255);
    check("c255_busy_n", 32'(bus.Busy), 32'd1);
    finish_capture(12'h255, "c255");
    check_digits(7'b0100100, 7'b0010010, 7'b0010010, "d255");

    // Single digit: tens and hundreds blanked.
    start_capture(8'd7);
    check("c7_valid_cleared", 32'(bus.Valid), 32'd0);
    finish_capture(12'h007, "c7");
    check_digits(7'h7F, 7'h7F, 7'b1111000, "d7");

    // Internal zeros stay lit.
    start_capture(8'd100);
    finish_capture(12'h100, "c100");
    check_digits(7'b1111001, 7'b1000000, 7'b1000000, "d100");

    // Retrigger during conversion is ignored.
    start_capture(8'd42);             // edge N
    tick();                           // N+1
    bus.Halt = 1'b0;
    tick();                           // N+2 samples Halt low
    bus.Halt = 1'b1;
    bus.Data = 8'd9;
    tick();                           // N+3 rise while converting
    check("retrig_busy_n3", 32'(bus.Busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("retrig_valid_n7", 32'(bus.Valid), 32'd0);
    tick();                           // N+8
    check("retrig_bcd", 32'(bus.Bcd), 32'h042);
    check("retrig_valid", 32'(bus.Valid), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("retrig_no_second_busy", 32'(bus.Busy), 32'd0);
    check("retrig_bcd_held", 32'(bus.Bcd), 32'h042);
    bus.Halt = 1'b0;

    // Reset mid-conversion aborts; Halt high at release captures immediately.
    start_capture(8'd200);            // edge N
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_valid", 32'(bus.Valid), 32'd0);
    check("abort_bcd", 32'(bus.Bcd), 32'h000);
    check("abort_anode", 32'(bus.Anode), 32'b110);
    check("abort_seg", 32'(bus.Segments), 32'h7F);
    tick();
    rst = 1'b0;
    bus.Data = 8'd200;
    tick();                           // first edge after release: capture
    check("relcap_busy", 32'(bus.Busy), 32'd1);
    finish_capture(12'h200, "c200");
    check_digits(7'b0100100, 7'b1000000, 7'b1000000, "d200");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
